// File: rtl/time_counter.sv
// time_counter -- HH:MM:SS time-of-day counter driven by a TICK_DIV-cycle
// prescaler, with debounced minute/hour set buttons and a synchronous clear.
// Optional feature macro: HOUR_COUNTER_EN. When it is undefined the hours
// output is tied to zero, the minute carry is dropped and btn_hour is ignored.
module time_counter #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       clear,
   input  logic       btn_min,
   input  logic       btn_hour,
   output logic [7:0] seconds,
   output logic [7:0] minutes,
   output logic [7:0] hours,
   output logic       sec_tick
);

   // Prescaler width; TICK_DIV >= 2 guarantees at least one bit.
   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   localparam logic [7:0] SEC_MAX  = 8'd59;
   localparam logic [7:0] MIN_MAX  = 8'd59;

   // Modular increment: anything at or above the field maximum returns to 0,
   // so a field can never leave its range even from an unexpected value.
   function automatic logic [7:0] wrap_inc(input logic [7:0] value,
                                           input logic [7:0] max_value);
      if (value >= max_value) begin
         return 8'd0;
      end
      return value + 8'd1;
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    sec_q, sec_d;
   logic [7:0]    min_q, min_d;
   logic          sec_tick_q, sec_tick_d;

   // Edge-detect registers hold "button was seen released", so they reset to
   // 0 (disarmed): a button held through reset release cannot fire until it
   // has been released and pressed again.
   logic          min_arm_q, min_arm_d;

   logic          tick;
   logic          min_press;
   logic          min_carry;

   // Tick fires on the edge where the prescaler sits at its top value while
   // running; clear suppresses it.
   assign tick      = run && (presc_q == PRESC_MAX) && !clear;
   assign min_press = btn_min && min_arm_q;
   assign min_carry = tick && (sec_q >= SEC_MAX);

   // Next-state for prescaler, seconds, minutes and the minute button arm.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      presc_d    = presc_q;
      sec_d      = sec_q;
      min_d      = min_q;
      sec_tick_d = 1'b0;
      min_arm_d  = !btn_min;

      if (clear) begin
         presc_d = '0;
         sec_d   = 8'd0;
         min_d   = 8'd0;
      end else begin
         if (run) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
         end
         if (tick) begin
            sec_d      = wrap_inc(sec_q, SEC_MAX);
            sec_tick_d = 1'b1;
         end
         // A press and a tick carry landing together still give only +1.
         if (min_press || min_carry) begin
            min_d = wrap_inc(min_q, MIN_MAX);
         end
      end
   end

   // State registers for prescaler, seconds, minutes, pulse and minute arm.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         presc_q    <= '0;
         sec_q      <= 8'd0;
         min_q      <= 8'd0;
         sec_tick_q <= 1'b0;
         min_arm_q  <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         sec_tick_q <= sec_tick_d;
         min_arm_q  <= min_arm_d;
      end
   end

`ifdef HOUR_COUNTER_EN
   localparam logic [7:0] HOUR_MAX = 8'd23;

   logic [7:0] hour_q, hour_d;
   logic       hour_arm_q, hour_arm_d;
   logic       hour_press;
   logic       hour_carry;

   assign hour_press = btn_hour && hour_arm_q;
   // A manual minute press replaces the tick carry into minutes, so it also
   // cancels any carry onward into hours.
   assign hour_carry = min_carry && !min_press && (min_q >= MIN_MAX);

   // Next-state for hours and the hour button arm.
   always_comb begin
      hour_d     = hour_q;
      hour_arm_d = !btn_hour;
      if (clear) begin
         hour_d = 8'd0;
      end else if (hour_press || hour_carry) begin
         hour_d = wrap_inc(hour_q, HOUR_MAX);
      end
   end

   // Hours and hour-arm registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hour_q     <= 8'd0;
         hour_arm_q <= 1'b0;
      end else begin
         hour_q     <= hour_d;
         hour_arm_q <= hour_arm_d;
      end
   end

   assign hours = hour_q;
`else
   // No hour logic: the button input is deliberately left without a load.
   logic unused_btn_hour;
   assign unused_btn_hour = btn_hour;
   assign hours           = 8'd0;
`endif

   assign seconds  = sec_q;
   assign minutes  = min_q;
   assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter -- scoreboard bench for time_counter with TICK_DIV=4.
// A behavioural model predicts each cycle's outputs; the prediction is queued
// when the inputs are driven and compared after the clock edge. Directed
// scenarios add fixed-value checks on top. Honours HOUR_COUNTER_EN.
module tb_time_counter;

   localparam int unsigned TICK_DIV = 4;

   typedef struct packed {
      logic [7:0] sec;
      logic [7:0] min;
      logic [7:0] hr;
      logic       tick;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       clear = 1'b0;
   logic       btn_min = 1'b0;
   logic       btn_hour = 1'b0;
   logic [7:0] seconds, minutes, hours;
   logic       sec_tick;

   int n_vec = 0;
   int n_err = 0;

   exp_t exp_q[$];

   // Reference state
   int m_presc, m_sec, m_min, m_hr;
   bit m_tick, m_arm_min, m_arm_hr;

   time_counter #(.TICK_DIV(TICK_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .clear    (clear),
      .btn_min  (btn_min),
      .btn_hour (btn_hour),
      .seconds  (seconds),
      .minutes  (minutes),
      .hours    (hours),
      .sec_tick (sec_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0;
      m_tick = 0; m_arm_min = 0; m_arm_hr = 0;
   endtask

   // Predict the state after the next rising edge from the driven inputs.
   task automatic model_step();
      bit tk, pm, cm;
`ifdef HOUR_COUNTER_EN
      bit ph, ch;
      ph = btn_hour && m_arm_hr;
`endif
      tk = run && (m_presc == TICK_DIV - 1) && !clear;
      pm = btn_min && m_arm_min;
      m_arm_min = !btn_min;
      m_arm_hr  = !btn_hour;
      if (clear) begin
         m_presc = 0; m_sec = 0; m_min = 0; m_hr = 0; m_tick = 0;
      end else begin
         if (run) m_presc = (m_presc + 1) % TICK_DIV;
         m_tick = tk;
         cm = tk && (m_sec == 59);
         if (tk) m_sec = (m_sec + 1) % 60;
`ifdef HOUR_COUNTER_EN
         ch = 0;
`endif
         if (pm) begin
            m_min = (m_min + 1) % 60;
         end else if (cm) begin
`ifdef HOUR_COUNTER_EN
            ch = (m_min == 59);
`endif
            m_min = (m_min + 1) % 60;
         end
`ifdef HOUR_COUNTER_EN
         if (ph || ch) m_hr = (m_hr + 1) % 24;
`endif
      end
   endtask

   // Drive one cycle of inputs, queue the prediction, compare after the edge.
   task automatic step(input logic r, input logic c, input logic bm, input logic bh);
      exp_t e;
      run = r; clear = c; btn_min = bm; btn_hour = bh;
      model_step();
      e.sec = 8'(m_sec); e.min = 8'(m_min); e.hr = 8'(m_hr); e.tick = m_tick;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check("sb_sec",  seconds,  e.sec);
         check("sb_min",  minutes,  e.min);
         check("sb_hour", hours,    e.hr);
         check("sb_tick", sec_tick, e.tick);
      end
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic press_hour(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         step(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // Pulse reset mid-cycle, away from clock edges, and check the async clear.
   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("rst_sec",  seconds,  0);
      check("rst_min",  minutes,  0);
      check("rst_hour", hours,    0);
      check("rst_tick", sec_tick, 0);
      #2 reset = 1'b0;
   endtask

   function automatic int hr_exp(input int v);
`ifdef HOUR_COUNTER_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   initial begin
      int pulses, first_p, last_p, off_grid;
      model_reset();

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      check("init_sec",  seconds,  0);
      check("init_min",  minutes,  0);
      check("init_hour", hours,    0);
      check("init_tick", sec_tick, 0);
      #3 reset = 1'b0;

      // Free run 40 cycles: ten ticks at cycles 5, 9, ..., 41
      pulses = 0; first_p = 0; last_p = 0; off_grid = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         if (sec_tick) begin
            if (pulses == 0) first_p = i + 1;
            last_p = i + 1;
            pulses++;
            if ((i + 1 - 5) % TICK_DIV != 0) off_grid++;
         end
      end
      check("run40_sec",      seconds, 10);
      check("run40_pulses",   pulses,  10);
      check("run40_first",    first_p, 5);
      check("run40_last",     last_p,  41);
      check("run40_off_grid", off_grid, 0);

      // Preload 23:59:58, then 8 cycles wrap to 00:00:00
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(58 * TICK_DIV, 1'b1);
      press_hour(23);
      press_min(59);
      check("pre_sec",  seconds, 58);
      check("pre_min",  minutes, 59);
      check("pre_hour", hours,   hr_exp(23));
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0);
         if (sec_tick) pulses++;
      end
      check("wrap_sec",    seconds, 0);
      check("wrap_min",    minutes, 0);
      check("wrap_hour",   hours,   0);
      check("wrap_pulses", pulses,  2);

      // Manual minute at 59 does not carry; held button counts once
      step(1'b0, 1'b1, 1'b0, 1'b0);
      press_hour(5);
      press_min(59);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check("man59_min",  minutes, 0);
      check("man59_hour", hours,   hr_exp(5));
      check("man59_sec",  seconds, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      check("held_min",  minutes, 1);
      check("held_hour", hours,   hr_exp(5));
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Press on the same edge as the 59->0 seconds carry: +1 only
      step(1'b0, 1'b1, 1'b0, 1'b0);
      press_min(10);
      idle(59 * TICK_DIV + TICK_DIV - 1, 1'b1);
      check("conf_pre_sec", seconds, 59);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("conf_min",  minutes,  11);
      check("conf_sec",  seconds,  0);
      check("conf_tick", sec_tick, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // run=0 freezes seconds and prescaler; hour button still works
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(6, 1'b1);
      idle(24, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(25, 1'b0);
      check("frz_sec",  seconds, 1);
      check("frz_hour", hours,   hr_exp(1));
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("frz_resume1", seconds, 1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("frz_resume2", seconds, 2);

      // Clear mid-count with btn_min high
      press_min(3);
      idle(7, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_sec",  seconds,  0);
      check("clr_min",  minutes,  0);
      check("clr_hour", hours,    0);
      check("clr_tick", sec_tick, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_hold_tick", sec_tick, 0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      check("clr_after_min", minutes, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid-count with btn_min held through release
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("rstpre_min", minutes, 1);
      async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      check("rst_held_min", minutes, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("rst_repress_min", minutes, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // 00:59:59 plus one tick
      step(1'b0, 1'b1, 1'b0, 1'b0);
      press_min(59);
      idle(59 * TICK_DIV + TICK_DIV - 1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("mc_sec",  seconds, 0);
      check("mc_min",  minutes, 0);
      check("mc_hour", hours,   hr_exp(1));

      // Random mix against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, ($urandom % 50) == 0,
              ($urandom % 3) == 0, ($urandom % 3) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 Port: clk  input  1  system clock, single clock domain, rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: run  input  1  level; 1 = time advances, 0 = prescaler and seconds frozen.
REQ-005 Port: clear  input  1  synchronous level; zeroes all counters.
REQ-006 Port: btn_min  input  1  debounced level; rising edge increments minutes.
REQ-007 Port: btn_hour  input  1  debounced level; rising edge increments hours.
REQ-008 Port: seconds  output  8  registered, range 0..59, feeds the tens/ones digit splitter.
REQ-009 Port: minutes  output  8  registered, range 0..59, same downstream format.
REQ-010 Port: hours  output  8  registered, range 0..23.
REQ-011 Port: sec_tick  output  1  registered one-cycle pulse, coincident with each new seconds value.

Function
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 while run=1, wrap to 0, hold its value while run=0.
REQ-013 Tick SHALL occur on the edge where prescaler=TICK_DIV-1 and run=1; seconds increment on that edge, so seconds period = TICK_DIV cycles exactly.
REQ-014 sec_tick SHALL be 1 for exactly the cycle after each tick edge, 0 otherwise.
REQ-015 Seconds SHALL wrap 59->0 on tick and generate a minute carry in the same edge.
REQ-016 Minutes SHALL wrap 59->0 on carry and generate an hour carry in the same edge; hours SHALL wrap 23->0.
REQ-017 btn_min/btn_hour SHALL be rising-edge detected with one internal register each; a held level increments once; the increment applies on the edge after the 0->1 sample.
REQ-018 Manual increments SHALL NOT carry: minute 59->0 leaves hours unchanged; seconds unaffected.
REQ-019 Manual increments SHALL work regardless of run.
REQ-020 Same-edge conflict: a manual increment on a field overrides the tick carry into that field (field +1 only, not +2); the tick's effect on lower fields still applies.
REQ-021 clear=1 SHALL zero prescaler, seconds, minutes and hours and suppress sec_tick; clear has priority over tick and buttons.
REQ-022 Outputs SHALL never leave their stated ranges; all arithmetic is modular within 8-bit registers.

Reset
REQ-023 reset=1 SHALL asynchronously force prescaler, seconds, minutes, hours, sec_tick and both edge-detect registers to 0.
REQ-024 After reset deassertion the first tick SHALL occur TICK_DIV cycles after run is first sampled 1.
REQ-025 Buttons held high through reset release SHALL NOT produce an increment until released and pressed again.

Configuration
REQ-026 Macro HOUR_COUNTER_EN: when defined, hours counter, hour carry and btn_hour behave as above.
REQ-027 Without HOUR_COUNTER_EN: hours output constant 0, minute carry discarded (minutes wrap 59->0 only), btn_hour ignored, no hour logic synthesized.

Verification (TICK_DIV=4 unless stated)
REQ-028 Reset released, run=1 for 40 cycles -> seconds=10, sec_tick pulsed 10 times, each pulse at cycles 5,9,13,...
REQ-029 Preload 23:59:58 via buttons/ticks, run 8 cycles -> 00:00:00 with hours wrap and two sec_tick pulses.
REQ-030 minutes=59, hours=5, single btn_min press -> minutes=0, hours=5; btn_min held 100 cycles -> exactly one increment.
REQ-031 seconds=59, btn_min rising edge on the tick edge, minutes=10 -> minutes=11 (not 12), seconds=0.
REQ-032 run=0 for 50 cycles mid-count -> seconds and prescaler unchanged; btn_hour press still increments hours.
REQ-033 clear and reset each asserted mid-count with btn_min high -> all outputs 0; without HOUR_COUNTER_EN, 00:59:59 plus one tick -> minutes=0, hours=0.
